// File: rtl/vliw_fetch.sv
// VLIW fetch stage: owns the PC, keeps at most one memory request in flight,
// and buffers returned words in a small FIFO whose head feeds the splitter.
module vliw_fetch #(
    parameter int                    cores      = 1,
    parameter int                    inst_len   = 32,
    parameter int                    addr_width = 32,
    parameter int                    fifo_depth = 2,
    parameter logic [addr_width-1:0] reset_pc   = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      mem_req,
    output logic [addr_width-1:0]     mem_addr,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [inst_len*cores-1:0] mem_rdata,
    input  logic                      redirect,
    input  logic [addr_width-1:0]     redirect_pc,
    output logic [inst_len*cores-1:0] vliw,
    output logic                      vliw_valid,
    input  logic                      vliw_ready,
    output logic [addr_width-1:0]     vliw_pc
);
    localparam int W    = inst_len * cores;
    localparam int STEP = W / 8;
    localparam int PW   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW   = $clog2(fifo_depth + 1);
    localparam logic [addr_width-1:0] STEP_A = addr_width'(STEP);
    localparam logic [CW:0]           DEPTH_C = (CW+1)'(fifo_depth);
    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [addr_width-1:0] pc_q, pc_d;
    logic [addr_width-1:0] tag_q, tag_d;
    logic                  drop_q, drop_d;
    logic                  active_q;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [W-1:0]          data_q [fifo_depth];
    logic [addr_width-1:0] addr_q [fifo_depth];

    logic [CW:0] used_s;
    logic        credit_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(fifo_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts the in-flight word so a response always has a FIFO slot.
    assign used_s     = {1'b0, count_q} + {{CW{1'b0}}, (state_q == ST_WAIT)};
    assign credit_s   = used_s < DEPTH_C;
    assign mem_req    = active_q && (state_q == ST_REQ) && credit_s;
    assign mem_addr   = pc_q;
    assign accept_s   = mem_req && mem_ready;
    assign vliw_valid = (count_q != '0);
    assign push_s     = (state_q == ST_WAIT) && mem_rvalid && !drop_q && !redirect;
    assign pop_s      = vliw_valid && vliw_ready && !redirect;
    assign vliw       = vliw_valid ? data_q[rd_ptr_q] : '0;
    assign vliw_pc    = vliw_valid ? addr_q[rd_ptr_q] : '0;

    // Request/response sequencing, PC advance and squash tracking.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        drop_d  = drop_q;
        pc_d    = redirect ? redirect_pc : (accept_s ? pc_q + STEP_A : pc_q);
        case (state_q)
            ST_REQ: begin
                if (accept_s) begin
                    state_d = ST_WAIT;
                    tag_d   = pc_q;
                    drop_d  = redirect;
                end else begin
                    drop_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end else if (redirect) begin
                    drop_d  = 1'b1;
                end else begin
                    drop_d  = drop_q;
                end
            end
            default: begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    // FIFO pointer and occupancy update; redirect empties the buffer.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = push_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop_s ? next_ptr(rd_ptr_q) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_REQ;
            pc_q     <= reset_pc;
            tag_q    <= '0;
            drop_q   <= 1'b0;
            active_q <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tag_q    <= tag_d;
            drop_q   <= drop_d;
            active_q <= 1'b1;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observed through count_q.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_q[wr_ptr_q] <= mem_rdata;
            addr_q[wr_ptr_q] <= tag_q;
        end
    end
endmodule
